// File: rtl/clkrst_seq_pkg.sv
// ---------------------------------------------------------------------------
// clkrst_seq_pkg
// Shared definitions for the clock/reset release sequencer:
//   - state_e        : sequencer state encoding
//   - SYNC_STAGES_MIN: shallowest legal reset synchroniser
//   - NUM_CH_MAX     : largest supported channel count
// Optional feature macro: CLKRST_SEQ_SOFT_RST_EN adds the SOFT state.
// ---------------------------------------------------------------------------
package clkrst_seq_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int NUM_CH_MAX      = 16;

    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_GAP     = 3'd1,
        ST_RELEASE = 3'd2,
`ifdef CLKRST_SEQ_SOFT_RST_EN
        ST_RUN     = 3'd3,
        ST_SOFT    = 3'd4
`else
        ST_RUN     = 3'd3
`endif
    } state_e;

endpackage

// File: rtl/clkrst_rst_sync.sv
// ---------------------------------------------------------------------------
// clkrst_rst_sync
// Reset synchroniser: asserts asynchronously, deasserts after STAGES rising
// edges of clk. Reusable for any single-clock reset domain.
// Ports:
//   clk        - clock
//   rst_n      - asynchronous active-low reset in
//   rst_sync_n - active-low reset out, deassertion synchronous to clk
// ---------------------------------------------------------------------------
module clkrst_rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic rst_sync_n
);

    logic [STAGES-1:0] chain;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n = chain[STAGES-1];

endmodule

// File: rtl/clkrst_seq.sv
// ---------------------------------------------------------------------------
// clkrst_seq
// Releases NUM_CH clock/reset channels one at a time after power-on reset:
// for each channel wait GAP_CYCLES, enable its clock, then one cycle later
// release its reset. hold_i freezes the sequence. Once all channels run,
// seq_done_o goes high.
// Optional macro CLKRST_SEQ_SOFT_RST_EN: per-channel 4-phase soft reset
// (soft_req_i / soft_ack_o) serviced one channel at a time from RUN.
// Without it soft_req_i is ignored and soft_ack_o is tied to 0.
// Ports:
//   axis_clk    - clock, all flops on rising edge
//   axis_rst_n  - asynchronous active-low reset
//   hold_i      - freeze release sequence while high
//   soft_req_i  - per-channel soft-reset request
//   soft_ack_o  - per-channel soft-reset acknowledge
//   ch_clk_en_o - per-channel clock enable
//   ch_rst_n_o  - per-channel active-low reset
//   seq_done_o  - all channels released
// ---------------------------------------------------------------------------
module clkrst_seq
    import clkrst_seq_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int GAP_CYCLES  = 8
) (
    input  logic              axis_clk,
    input  logic              axis_rst_n,
    input  logic              hold_i,
    input  logic [NUM_CH-1:0] soft_req_i,
    output logic [NUM_CH-1:0] soft_ack_o,
    output logic [NUM_CH-1:0] ch_clk_en_o,
    output logic [NUM_CH-1:0] ch_rst_n_o,
    output logic              seq_done_o
);

    localparam int CNT_W  = $clog2(GAP_CYCLES + 1);
    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SYNC_N = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

    logic             sync_rst_n;
    state_e           state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;

    clkrst_rst_sync #(
        .STAGES (SYNC_N)
    ) u_rst_sync (
        .clk        (axis_clk),
        .rst_n      (axis_rst_n),
        .rst_sync_n (sync_rst_n)
    );

`ifdef CLKRST_SEQ_SOFT_RST_EN
    logic             soft_pend;
    logic [IDX_W-1:0] soft_sel;

    // Lowest-index channel with an unacknowledged request. Requests made
    // before RUN simply stay pending here until RUN is reached.
    // NOTE: every always_comb output gets a default first, otherwise paths
    // that skip an assignment infer a latch.
    always_comb begin
        soft_pend = 1'b0;
        soft_sel  = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (soft_req_i[k] && !soft_ack_o[k]) begin
                soft_pend = 1'b1;
                soft_sel  = IDX_W'(k);
            end
        end
    end
`else
    logic unused_soft_req;
    assign unused_soft_req = ^soft_req_i;
    assign soft_ack_o      = '0;
`endif

    // NOTE: all state here is control, not storage, so everything is reset;
    // there is no memory array that could be left unreset.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state       <= ST_HOLD;
            idx         <= '0;
            cnt         <= '0;
            ch_clk_en_o <= '0;
            ch_rst_n_o  <= '0;
            seq_done_o  <= 1'b0;
`ifdef CLKRST_SEQ_SOFT_RST_EN
            soft_ack_o  <= '0;
`endif
        end else begin
`ifdef CLKRST_SEQ_SOFT_RST_EN
            // Acks drop once the requester withdraws; SOFT exit overrides below.
            soft_ack_o <= soft_ack_o & soft_req_i;
`endif
            case (state)
                ST_HOLD: begin
                    if (sync_rst_n && !hold_i) begin
                        state <= ST_GAP;
                        cnt   <= '0;
                    end
                end
                ST_GAP: begin
                    if (!hold_i) begin
                        if (cnt == CNT_LAST) begin
                            ch_clk_en_o[idx] <= 1'b1;
                            state            <= ST_RELEASE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (!hold_i) begin
                        ch_rst_n_o[idx] <= 1'b1;
                        if (idx == IDX_LAST) begin
                            state      <= ST_RUN;
                            seq_done_o <= 1'b1;
                        end else begin
                            idx   <= idx + 1'b1;
                            cnt   <= '0;
                            state <= ST_GAP;
                        end
                    end
                end
`ifdef CLKRST_SEQ_SOFT_RST_EN
                ST_RUN: begin
                    // idx is free once every channel is released, so it
                    // carries the channel under soft reset.
                    if (soft_pend) begin
                        idx                  <= soft_sel;
                        cnt                  <= '0;
                        ch_rst_n_o[soft_sel] <= 1'b0;
                        state                <= ST_SOFT;
                    end
                end
                ST_SOFT: begin
                    if (cnt == CNT_LAST) begin
                        ch_rst_n_o[idx] <= 1'b1;
                        soft_ack_o[idx] <= 1'b1;
                        state           <= ST_RUN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`else
                ST_RUN: begin
                end
`endif
                default: begin
                    state <= ST_HOLD;
                end
            endcase
        end
    end

endmodule
